efgj03l_video_shifter: RTL and testbench

Pixel serializer on the consumer side of the EFGJ03L video timing/DRAM address generator. Captures the point byte and colour byte the gate array fetches with PIN_nCASPT / PIN_nCASCOL and shifts them out MSB-first at the PIN_POINT dot rate. Output is a 4-bit RGBI pixel stream, gated by the gate array's active-area (PIN_nINILT) and blanking (PIN_nSUPLT) signals, with sync delayed to stay aligned.

---
 rtl/efgj03l_video_shifter.sv | 213 +++++++++++++++++++++
 tb/tb_efgj03l_video_shifter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/efgj03l_video_shifter.sv
// efgj03l_video_shifter: serializes the point/colour byte pair fetched by the
// gate array into a 4-bit RGBI dot stream, with border, blanking and sync.
//
// Ports:
//   PIN_H16      16 MHz clock, all logic on the rising edge
//   nPIN_SYCL    synchronous active-low reset
//   PIN_POINT    8 MHz dot clock; a rising edge is one dot tick
//   PIN_nCASPT   rising edge latches MD as the point byte
//   PIN_nCASCOL  rising edge latches MD as the colour byte
//   MD           DRAM read data
//   PIN_nINILT   0 = active area, 1 = border
//   PIN_nSUPLT   0 = force black
//   PIN_SYNLT    composite sync in
//   BORDER_WE/D  border colour write strobe and data
//   ERR_CLR      clears the sticky error flags
//   PIX_RGBI     pixel colour, updated on dot ticks
//   SYNC_OUT     PIN_SYNLT aligned with PIX_RGBI
//   BLANK_OUT    1 = PIX_RGBI forced black
//   ERR_UNDER    sticky: load was due with no byte pair ready
//   ERR_OVER     sticky: a holding byte was overwritten unconsumed

module efgj03l_video_shifter #(
    parameter logic [3:0] BORDER_RST = 4'h0
) (
    input  logic       PIN_H16,
    input  logic       nPIN_SYCL,
    input  logic       PIN_POINT,
    input  logic       PIN_nCASPT,
    input  logic       PIN_nCASCOL,
    input  logic [7:0] MD,
    input  logic       PIN_nINILT,
    input  logic       PIN_nSUPLT,
    input  logic       PIN_SYNLT,
    input  logic       BORDER_WE,
    input  logic [3:0] BORDER_D,
    input  logic       ERR_CLR,
    output logic [3:0] PIX_RGBI,
    output logic       SYNC_OUT,
    output logic       BLANK_OUT,
    output logic       ERR_UNDER,
    output logic       ERR_OVER
);

    // Edge-detect history
    logic       point_q, caspt_q, cascol_q;

    // Holding stage
    logic [7:0] pt_hold_q, pt_hold_d;
    logic [7:0] col_hold_q, col_hold_d;
    logic       pt_full_q, pt_full_d;
    logic       col_full_q, col_full_d;

    // Shifter
    logic [7:0] shreg_q, shreg_d;
    logic [3:0] fg_q, fg_d;
    logic [3:0] bg_q, bg_d;
    logic [2:0] cnt_q, cnt_d;
    logic       loaded_q, loaded_d;

    // Output / control registers
    logic [3:0] border_q, border_d;
    logic [3:0] pix_q, pix_d;
    logic       sync_q, sync_d;
    logic       blank_q, blank_d;
    logic       under_q, under_d;
    logic       over_q, over_d;

    logic dot_tick, pt_edge, col_edge, active;
    logic pair_ready, load_due, do_load, do_under, do_shift;

    assign dot_tick   = PIN_POINT & ~point_q;
    assign pt_edge    = PIN_nCASPT & ~caspt_q;
    assign col_edge   = PIN_nCASCOL & ~cascol_q;
    assign active     = ~PIN_nINILT;
    assign pair_ready = pt_full_q & col_full_q;

    // A group starts on the first active tick after a border/underrun
    // (loaded=0) or after the eighth dot of the current group.
    assign load_due = dot_tick & active & (~loaded_q | (cnt_q == 3'd7));
    assign do_load  = load_due & pair_ready;
    assign do_under = load_due & ~pair_ready;
    assign do_shift = dot_tick & active & ~load_due;

    always_comb begin
        pt_hold_d  = pt_hold_q;
        col_hold_d = col_hold_q;
        pt_full_d  = pt_full_q;
        col_full_d = col_full_q;
        shreg_d    = shreg_q;
        fg_d       = fg_q;
        bg_d       = bg_q;
        cnt_d      = cnt_q;
        loaded_d   = loaded_q;
        border_d   = border_q;
        pix_d      = pix_q;
        sync_d     = sync_q;
        blank_d    = blank_q;
        under_d    = under_q;
        over_d     = over_q;

        // Consume first, then capture: a CAS edge in the load cycle
        // leaves the new byte held with its flag set.
        if (do_load) begin
            pt_full_d  = 1'b0;
            col_full_d = 1'b0;
        end
        if (pt_edge) begin
            pt_hold_d = MD;
            pt_full_d = 1'b1;
        end
        if (col_edge) begin
            col_hold_d = MD;
            col_full_d = 1'b1;
        end

        if (do_load) begin
            shreg_d  = pt_hold_q;
            fg_d     = col_hold_q[7:4];
            bg_d     = col_hold_q[3:0];
            cnt_d    = 3'd0;
            loaded_d = 1'b1;
        end else if (do_under) begin
            loaded_d = 1'b0;
        end else if (do_shift) begin
            cnt_d   = cnt_q + 3'd1;
            shreg_d = {shreg_q[6:0], 1'b0};
        end else if (dot_tick) begin
            cnt_d    = 3'd0;
            loaded_d = 1'b0;
        end

        if (dot_tick) begin
            sync_d  = PIN_SYNLT;
            blank_d = ~PIN_nSUPLT;
            if (!PIN_nSUPLT) begin
                pix_d = 4'h0;
            end else if (PIN_nINILT) begin
                pix_d = border_q;
            end else if (do_under) begin
                // Repeat the last background; bg is black after reset
                pix_d = bg_q;
            end else begin
                pix_d = shreg_d[7] ? fg_d : bg_d;
            end
        end

        if (BORDER_WE) begin
            border_d = BORDER_D;
        end

        if (do_under) begin
            under_d = 1'b1;
        end else if (ERR_CLR) begin
            under_d = 1'b0;
        end

        if ((pt_edge & pt_full_q & ~do_load) |
            (col_edge & col_full_q & ~do_load)) begin
            over_d = 1'b1;
        end else if (ERR_CLR) begin
            over_d = 1'b0;
        end
    end

    always_ff @(posedge PIN_H16) begin
        if (!nPIN_SYCL) begin
            point_q    <= 1'b0;
            caspt_q    <= 1'b0;
            cascol_q   <= 1'b0;
            pt_hold_q  <= 8'h00;
            col_hold_q <= 8'h00;
            pt_full_q  <= 1'b0;
            col_full_q <= 1'b0;
            shreg_q    <= 8'h00;
            fg_q       <= 4'h0;
            bg_q       <= 4'h0;
            cnt_q      <= 3'd0;
            loaded_q   <= 1'b0;
            border_q   <= BORDER_RST;
            pix_q      <= 4'h0;
            sync_q     <= 1'b0;
            blank_q    <= 1'b1;
            under_q    <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            point_q    <= PIN_POINT;
            caspt_q    <= PIN_nCASPT;
            cascol_q   <= PIN_nCASCOL;
            pt_hold_q  <= pt_hold_d;
            col_hold_q <= col_hold_d;
            pt_full_q  <= pt_full_d;
            col_full_q <= col_full_d;
            shreg_q    <= shreg_d;
            fg_q       <= fg_d;
            bg_q       <= bg_d;
            cnt_q      <= cnt_d;
            loaded_q   <= loaded_d;
            border_q   <= border_d;
            pix_q      <= pix_d;
            sync_q     <= sync_d;
            blank_q    <= blank_d;
            under_q    <= under_d;
            over_q     <= over_d;
        end
    end

    assign PIX_RGBI  = pix_q;
    assign SYNC_OUT  = sync_q;
    assign BLANK_OUT = blank_q;
    assign ERR_UNDER = under_q;
    assign ERR_OVER  = over_q;

endmodule

// File: tb/tb_efgj03l_video_shifter.sv
// tb_efgj03l_video_shifter: directed, table-driven bench for the
// video shifter, plus hand-written corner-case sequences.

module tb_efgj03l_video_shifter;

    logic       clk = 1'b0;
    logic       nrst;
    logic       point, ncaspt, ncascol;
    logic [7:0] md;
    logic       ninilt, nsuplt, synlt;
    logic       bwe;
    logic [3:0] bd;
    logic       eclr;
    logic [3:0] pix;
    logic       sync_o, blank_o, eu, eo;

    int checks = 0;
    int errors = 0;

    efgj03l_video_shifter #(.BORDER_RST(4'h6)) dut (
        .PIN_H16    (clk),
        .nPIN_SYCL  (nrst),
        .PIN_POINT  (point),
        .PIN_nCASPT (ncaspt),
        .PIN_nCASCOL(ncascol),
        .MD         (md),
        .PIN_nINILT (ninilt),
        .PIN_nSUPLT (nsuplt),
        .PIN_SYNLT  (synlt),
        .BORDER_WE  (bwe),
        .BORDER_D   (bd),
        .ERR_CLR    (eclr),
        .PIX_RGBI   (pix),
        .SYNC_OUT   (sync_o),
        .BLANK_OUT  (blank_o),
        .ERR_UNDER  (eu),
        .ERR_OVER   (eo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  pt;
        logic [7:0]  col;
        logic [31:0] pix;
    } vec_t;

    vec_t tbl[5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic dot();
        point = 1'b1;
        step();
        point = 1'b0;
        step();
    endtask

    task automatic cas_pt(input logic [7:0] b);
        md     = b;
        ncaspt = 1'b1;
        step();
        ncaspt = 1'b0;
    endtask

    task automatic cas_col(input logic [7:0] b);
        md      = b;
        ncascol = 1'b1;
        step();
        ncascol = 1'b0;
    endtask

    initial begin
        tbl[0] = '{8'hA5, 8'h3C, 32'h3C3CC3C3};
        tbl[1] = '{8'hFF, 8'h70, 32'h77777777};
        tbl[2] = '{8'h00, 8'h70, 32'h00000000};
        tbl[3] = '{8'h0F, 8'h95, 32'h55559999};
        tbl[4] = '{8'h81, 8'hE2, 32'hE222222E};

        nrst = 1'b0; point = 1'b0; ncaspt = 1'b0; ncascol = 1'b0;
        md = 8'h00; ninilt = 1'b0; nsuplt = 1'b1; synlt = 1'b1;
        bwe = 1'b0; bd = 4'h0; eclr = 1'b0;

        // Reset held with active stimulus running
        for (int i = 0; i < 4; i++) begin
            point   = ~point;
            ncaspt  = ~ncaspt;
            ncascol = ~ncascol;
            md      = 8'hA5;
            step();
            chk("rst_pix", {4'h0, pix}, 8'h00);
            chk("rst_blank", {7'h0, blank_o}, 8'h01);
            chk("rst_sync", {7'h0, sync_o}, 8'h00);
            chk("rst_err", {6'h0, eu, eo}, 8'h00);
        end

        nrst = 1'b1; point = 1'b0; ncaspt = 1'b0; ncascol = 1'b0;
        ninilt = 1'b1; synlt = 1'b0;
        step();
        chk("rel_blank_hold", {7'h0, blank_o}, 8'h01);
        dot();
        chk("first_tick_blank", {7'h0, blank_o}, 8'h00);
        chk("first_tick_border", {4'h0, pix}, 8'h06);

        // Table-driven back-to-back groups, next pair delivered mid-group
        cas_pt(tbl[0].pt);
        cas_col(tbl[0].col);
        ninilt = 1'b0;
        for (int g = 0; g < 5; g++) begin
            for (int i = 0; i < 8; i++) begin
                dot();
                chk($sformatf("grp%0d_pix%0d", g, i), {4'h0, pix},
                    {4'h0, tbl[g].pix[31-4*i -: 4]});
                if (i == 0)
                    chk($sformatf("grp%0d_err", g), {6'h0, eu, eo}, 8'h00);
                if (i == 2 && g < 4) begin
                    cas_pt(tbl[g+1].pt);
                    cas_col(tbl[g+1].col);
                end
            end
        end

        // Underrun: no pair for the next group
        for (int i = 0; i < 8; i++) begin
            dot();
            chk($sformatf("under_pix%0d", i), {4'h0, pix}, 8'h02);
        end
        chk("under_flag", {7'h0, eu}, 8'h01);
        chk("under_no_over", {7'h0, eo}, 8'h00);
        eclr = 1'b1;
        step();
        eclr = 1'b0;
        chk("under_clr", {7'h0, eu}, 8'h00);

        // Overrun in border
        ninilt = 1'b1;
        dot();
        cas_pt(8'h11);
        step();
        chk("over_none_yet", {7'h0, eo}, 8'h00);
        cas_pt(8'h22);
        step();
        chk("over_flag", {7'h0, eo}, 8'h01);
        eclr = 1'b1;
        step();
        eclr = 1'b0;
        chk("over_clr", {7'h0, eo}, 8'h00);

        // Colour CAS edge in the very cycle that loads the pair
        cas_col(8'h4B);
        step();
        ninilt  = 1'b0;
        md      = 8'hD2;
        ncascol = 1'b1;
        point   = 1'b1;
        step();
        ncascol = 1'b0;
        point   = 1'b0;
        step();
        chk("sim_pix0", {4'h0, pix}, 8'h0B);
        chk("sim_no_over", {7'h0, eo}, 8'h00);
        begin
            logic [31:0] exp1;
            exp1 = 32'hBB4BBB4B;
            for (int i = 1; i < 8; i++) begin
                dot();
                chk($sformatf("sim_pix%0d", i), {4'h0, pix},
                    {4'h0, exp1[31-4*i -: 4]});
                if (i == 1) cas_pt(8'h80);
            end
        end
        dot();
        chk("sim_new_col_fg", {4'h0, pix}, 8'h0D);
        dot();
        chk("sim_new_col_bg", {4'h0, pix}, 8'h02);
        chk("sim_err", {6'h0, eu, eo}, 8'h00);

        // Border write coinciding with a tick applies from the next tick
        ninilt = 1'b1;
        bd     = 4'h9;
        bwe    = 1'b1;
        point  = 1'b1;
        step();
        bwe    = 1'b0;
        point  = 1'b0;
        step();
        chk("border_old", {4'h0, pix}, 8'h06);
        dot();
        chk("border_new", {4'h0, pix}, 8'h09);
        chk("border_blank", {7'h0, blank_o}, 8'h00);

        // Blanking and sync change only on a tick
        nsuplt = 1'b0;
        synlt  = 1'b1;
        step();
        step();
        chk("hold_pix", {4'h0, pix}, 8'h09);
        chk("hold_sync", {7'h0, sync_o}, 8'h00);
        chk("hold_blank", {7'h0, blank_o}, 8'h00);
        dot();
        chk("blank_pix", {4'h0, pix}, 8'h00);
        chk("blank_flag", {7'h0, blank_o}, 8'h01);
        chk("blank_sync", {7'h0, sync_o}, 8'h01);
        nsuplt = 1'b1;
        synlt  = 1'b0;
        dot();
        chk("unblank_pix", {4'h0, pix}, 8'h09);
        chk("unblank_flag", {7'h0, blank_o}, 8'h00);
        chk("unblank_sync", {7'h0, sync_o}, 8'h00);

        // Mid-line reset
        ninilt = 1'b0;
        nrst   = 1'b0;
        step();
        chk("midrst_pix", {4'h0, pix}, 8'h00);
        chk("midrst_blank", {7'h0, blank_o}, 8'h01);
        nrst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
